// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: control inputs and display outputs of the stopwatch controller
interface stopwatch_ctrl_if;
  logic [1:0] mode;
  logic [15:0] preset;
  logic start;
  logic clear;
  logic [3:0] dig3;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic running;
  logic done;
  logic scan_tick;
  modport master (
    output mode, preset, start, clear,
    input dig3, dig2, dig1, dig0, running, done, scan_tick
  );
  modport slave (
    input mode, preset, start, clear,
    output dig3, dig2, dig1, dig0, running, done, scan_tick
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: four-mode SS.hh BCD stopwatch with start/pause/clear FSM and display scan strobe
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic rst,
  stopwatch_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(REFRESH_DIV + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(REFRESH_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, tgt, tgt_n, pre_val, start_val, tgt_val, stepped;
  logic up, up_n, tick;
  logic [PW-1:0] pre, pre_n;
  logic [SW-1:0] sc;
  function automatic logic [15:0] sanitize(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i+:4] > 4'd9) v[4*i+:4] = 4'd9;
    return v;
  endfunction
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic inc);
    logic c;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (inc) begin
          c = v[4*i+:4] == 4'd9;
          v[4*i+:4] = c ? 4'd0 : v[4*i+:4] + 4'd1;
        end else begin
          c = v[4*i+:4] == 4'd0;
          v[4*i+:4] = c ? 4'd9 : v[4*i+:4] - 4'd1;
        end
      end
    end
    return v;
  endfunction
  assign bus.dig3 = cnt[15:12];
  assign bus.dig2 = cnt[11:8];
  assign bus.dig1 = cnt[7:4];
  assign bus.dig0 = cnt[3:0];
  // next state, count and prescaler; mode/preset only take effect through IDLE or clear
  always_comb begin
    pre_val = sanitize(bus.preset);
    start_val = bus.mode == 2'b01 ? 16'h9999 : bus.mode == 2'b11 ? pre_val : 16'h0000;
    tgt_val = bus.mode == 2'b00 ? 16'h9999 : bus.mode == 2'b10 ? pre_val : 16'h0000;
    tick = pre == PMAX;
    stepped = bcd_step(cnt, up);
    state_n = state;
    cnt_n = cnt;
    tgt_n = tgt;
    up_n = up;
    pre_n = pre;
    if (bus.clear || state == IDLE) begin
      state_n = IDLE;
      cnt_n = start_val;
      tgt_n = tgt_val;
      up_n = !bus.mode[0];
      pre_n = '0;
      if (!bus.clear && bus.start) state_n = start_val == tgt_val ? DONE : RUN;
    end else begin
      case (state)
        RUN: begin
          pre_n = tick ? '0 : pre + PW'(1);
          cnt_n = tick ? stepped : cnt;
          state_n = (tick && stepped == tgt) ? DONE : bus.start ? PAUSE : RUN;
        end
        PAUSE: state_n = bus.start ? RUN : PAUSE;
        default: state_n = state;
      endcase
    end
  end
  // FSM, count and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tgt <= '0;
      up <= 1'b1;
      pre <= '0;
      bus.running <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tgt <= tgt_n;
      up <= up_n;
      pre <= pre_n;
      bus.running <= state_n == RUN;
      bus.done <= state_n == DONE;
    end
  end
  // free-running digit-scan strobe, one cycle every REFRESH_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sc <= '0;
      bus.scan_tick <= 1'b0;
    end else begin
      sc <= sc == SMAX ? '0 : sc + SW'(1);
      bus.scan_tick <= sc == SMAX;
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for the stopwatch controller with fast divider settings
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  stopwatch_ctrl_if sw();
  stopwatch_ctrl #(.TICK_DIV(4), .REFRESH_DIV(3)) dut (.clk(clk), .rst(rst), .bus(sw));
  typedef struct {
    int gap;
    logic [15:0] d;
    logic r;
    logic dn;
    string name;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int vectors = 0;
  int fails = 0;
  int sc_k = 0;
  bit mon_on = 1'b0;
  // clock generation
  always #5 clk = ~clk;
  // count clock edges since reset for the scan strobe reference
  always @(posedge clk) sc_k <= rst ? 0 : sc_k + 1;
  // scan_tick must pulse on edges 3, 6, 9, ... after reset
  always @(negedge clk) begin
    if (mon_on) begin
      vectors++;
      if (sw.scan_tick !== (sc_k != 0 && sc_k % 3 == 0)) begin
        fails++;
        $display("FAIL scan_tick at edge %0d: got %b expected %b", sc_k, sw.scan_tick, sc_k != 0 && sc_k % 3 == 0);
      end
    end
  end
  function automatic logic [15:0] dig();
    return {sw.dig3, sw.dig2, sw.dig1, sw.dig0};
  endfunction
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input int g, input logic [15:0] d, input logic r, input logic dn, input string n);
    q.push_back('{g, d, r, dn, n});
  endtask
  task automatic pulse_start();
    sw.start = 1'b1;
    adv(1);
    sw.start = 1'b0;
  endtask
  task automatic pulse_clear();
    sw.clear = 1'b1;
    adv(1);
    sw.clear = 1'b0;
  endtask
  task automatic test_reset();
    sw.mode = 2'b00;
    sw.preset = 16'h0000;
    sw.start = 1'b0;
    sw.clear = 1'b0;
    rst = 1'b1;
    adv(3);
    mon_on = 1'b1;
    push(0, 16'h0000, 1'b0, 1'b0, "reset_hold");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    rst = 1'b0;
    push(2, 16'h0000, 1'b0, 1'b0, "reset_idle");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
  endtask
  task automatic test_count_up();
    sw.mode = 2'b00;
    adv(2);
    pulse_start();
    push(0, 16'h0000, 1'b1, 1'b0, "up_run");
    push(3, 16'h0000, 1'b1, 1'b0, "up_before_tick");
    push(1, 16'h0001, 1'b1, 1'b0, "up_first_step");
    push(396, 16'h0100, 1'b1, 1'b0, "up_400_cycles");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_clear();
  endtask
  task automatic test_down_preset();
    sw.mode = 2'b11;
    sw.preset = 16'h0012;
    adv(2);
    push(0, 16'h0012, 1'b0, 1'b0, "dp_idle_preset");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_start();
    push(44, 16'h0001, 1'b1, 1'b0, "dp_11_ticks");
    push(4, 16'h0000, 1'b0, 1'b1, "dp_done");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_start();
    push(8, 16'h0000, 1'b0, 1'b1, "dp_start_ignored");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_clear();
  endtask
  task automatic test_pause();
    sw.mode = 2'b10;
    sw.preset = 16'h0105;
    adv(2);
    pulse_start();
    push(200, 16'h0050, 1'b1, 1'b0, "pause_reach_50");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_start();
    push(0, 16'h0050, 1'b0, 1'b0, "pause_enter");
    push(20, 16'h0050, 1'b0, 1'b0, "pause_hold");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_start();
    push(2, 16'h0050, 1'b1, 1'b0, "resume_no_early_step");
    push(1, 16'h0051, 1'b1, 1'b0, "resume_step");
    push(212, 16'h0104, 1'b1, 1'b0, "pause_before_target");
    push(4, 16'h0105, 1'b0, 1'b1, "pause_done_target");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_clear();
  endtask
  task automatic test_down_borrow();
    sw.mode = 2'b01;
    adv(2);
    push(0, 16'h9999, 1'b0, 1'b0, "down_idle");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_start();
    push(4, 16'h9998, 1'b1, 1'b0, "down_first");
    push(32, 16'h9990, 1'b1, 1'b0, "down_9990");
    push(4, 16'h9989, 1'b1, 1'b0, "down_borrow");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    adv(2);
    pulse_clear();
    push(0, 16'h9999, 1'b0, 1'b0, "down_clear_reload");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
  endtask
  task automatic test_edges();
    sw.mode = 2'b11;
    sw.preset = 16'h0000;
    adv(2);
    pulse_start();
    push(0, 16'h0000, 1'b0, 1'b1, "zero_preset_done");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_clear();
    sw.mode = 2'b10;
    sw.preset = 16'hF0A3;
    adv(2);
    push(0, 16'h0000, 1'b0, 1'b0, "sanitize_start");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_start();
    sw.preset = 16'h0001;
    push(36368, 16'h9092, 1'b1, 1'b0, "sanitize_before_target");
    push(4, 16'h9093, 1'b0, 1'b1, "sanitize_target");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_clear();
  endtask
  task automatic test_back_to_back();
    sw.mode = 2'b00;
    sw.preset = 16'h0000;
    adv(2);
    pulse_start();
    push(10, 16'h0002, 1'b1, 1'b0, "b2b_running");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    sw.start = 1'b1;
    sw.clear = 1'b1;
    adv(1);
    sw.start = 1'b0;
    sw.clear = 1'b0;
    push(0, 16'h0000, 1'b0, 1'b0, "clear_beats_start");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_start();
    adv(3);
    pulse_start();
    push(0, 16'h0001, 1'b0, 1'b0, "pause_on_tick_steps");
    push(8, 16'h0001, 1'b0, 1'b0, "pause_on_tick_hold");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_clear();
    sw.mode = 2'b10;
    sw.preset = 16'h0002;
    adv(2);
    pulse_start();
    push(7, 16'h0001, 1'b1, 1'b0, "before_terminal");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_clear();
    push(0, 16'h0000, 1'b0, 1'b0, "clear_beats_done");
    push(4, 16'h0000, 1'b0, 1'b0, "clear_beats_done_hold");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    pulse_start();
    push(5, 16'h0001, 1'b1, 1'b0, "before_mid_reset");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
    rst = 1'b1;
    adv(1);
    rst = 1'b0;
    push(0, 16'h0000, 1'b0, 1'b0, "mid_run_reset");
    push(10, 16'h0000, 1'b0, 1'b0, "after_reset_idle");
    while (q.size() > 0) begin
      e = q.pop_front(); adv(e.gap); vectors++;
      if ({dig(), sw.running, sw.done} !== {e.d, e.r, e.dn}) begin fails++; $display("FAIL %s: dig=%h run=%b done=%b, expected dig=%h run=%b done=%b", e.name, dig(), sw.running, sw.done, e.d, e.r, e.dn); end
    end
  endtask
  // run every scenario in order, then report
  initial begin
    test_reset();
    test_count_up();
    test_down_preset();
    test_pause();
    test_down_borrow();
    test_edges();
    test_back_to_back();
    adv(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
